// File: rtl/inst_decode_pipe.sv
// RV32I instruction decoder with an elastic valid/ready pipeline of STAGES registers.
// Decode happens combinationally on the incoming word; the registers only carry the decoded bundle.
module inst_decode_pipe #(
  parameter int XLEN          = 32,
  parameter int STAGES        = 2,
  parameter int CHECK_ILLEGAL = 1
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iValid,
  output logic            oReady,
  input  logic [XLEN-1:0] iInst,
  input  logic [XLEN-1:0] iCurPc,
  input  logic            iFlush,
  output logic            oValid,
  input  logic            iReady,
  output logic [6:0]      oOpcode,
  output logic [4:0]      oRdAddr,
  output logic [4:0]      oRs1Addr,
  output logic [4:0]      oRs2Addr,
  output logic [2:0]      oFunct3,
  output logic [6:0]      oFunct7,
  output logic [XLEN-1:0] oImm,
  output logic [XLEN-1:0] oCurPc,
  output logic            oLoad,
  output logic            oStore,
  output logic            oOpRs1,
  output logic            oOpRs2,
  output logic            oOpImm,
  output logic            oOpPc,
  output logic [3:0]      oArith,
  output logic            oIllegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ARITH_NOP = 4'b1111;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            load;
    logic            store;
    logic            op_rs1;
    logic            op_rs2;
    logic            op_imm;
    logic            op_pc;
    logic [3:0]      arith;
    logic            illegal;
  } bundle_t;

  function automatic logic is_illegal(input logic [XLEN-1:0] inst);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    f3  = inst[14:12];
    f7  = inst[31:25];
    ill = 1'b0;
    case (inst[6:0])
      OPC_OP: begin
        if (f7 == 7'b0100000)      ill = !(f3 == 3'b000 || f3 == 3'b101);
        else if (f7 != 7'b0000000) ill = 1'b1;
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001)      ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101) ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OPC_LOAD:   ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      OPC_STORE:  ill = (f3 > 3'b010);
      OPC_BRANCH: ill = (f3 == 3'b010) || (f3 == 3'b011);
      OPC_JALR:   ill = (f3 != 3'b000);
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_FENCE, OPC_SYSTEM: ill = 1'b0;
      default:    ill = 1'b1;
    endcase
    if (inst[1:0] != 2'b11) ill = 1'b1;
    return ill;
  endfunction

  // Fields a format does not define stay zero; FENCE/SYSTEM keep rd, rs1 and funct3 but no immediate.
  function automatic bundle_t decode(input logic [XLEN-1:0] inst, input logic [XLEN-1:0] pc);
    bundle_t b;
    logic    ill;
    b        = '0;
    b.opcode = inst[6:0];
    b.pc     = pc;
    b.arith  = ARITH_NOP;
    ill      = (CHECK_ILLEGAL != 0) ? is_illegal(inst) : 1'b0;
    if (ill) begin
      b.illegal = 1'b1;
    end else begin
      case (inst[6:0])
        OPC_OP: begin
          b.rd     = inst[11:7];
          b.rs1    = inst[19:15];
          b.rs2    = inst[24:20];
          b.f3     = inst[14:12];
          b.f7     = inst[31:25];
          b.arith  = {inst[30], inst[14:12]};
          b.op_rs1 = 1'b1;
          b.op_rs2 = 1'b1;
        end
        OPC_OPIMM: begin
          b.rd     = inst[11:7];
          b.rs1    = inst[19:15];
          b.f3     = inst[14:12];
          b.imm    = {{20{inst[31]}}, inst[31:20]};
          b.arith  = {(inst[14:12] == 3'b101) ? inst[30] : 1'b0, inst[14:12]};
          b.op_rs1 = 1'b1;
          b.op_imm = 1'b1;
        end
        OPC_LOAD: begin
          b.rd     = inst[11:7];
          b.rs1    = inst[19:15];
          b.f3     = inst[14:12];
          b.imm    = {{20{inst[31]}}, inst[31:20]};
          b.arith  = 4'b0000;
          b.load   = 1'b1;
          b.op_rs1 = 1'b1;
          b.op_imm = 1'b1;
        end
        OPC_STORE: begin
          b.rs1    = inst[19:15];
          b.rs2    = inst[24:20];
          b.f3     = inst[14:12];
          b.imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
          b.arith  = 4'b0000;
          b.store  = 1'b1;
          b.op_rs1 = 1'b1;
          b.op_imm = 1'b1;
        end
        OPC_BRANCH: begin
          b.rs1 = inst[19:15];
          b.rs2 = inst[24:20];
          b.f3  = inst[14:12];
          b.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end
        OPC_JALR: begin
          b.rd    = inst[11:7];
          b.rs1   = inst[19:15];
          b.f3    = inst[14:12];
          b.imm   = {{20{inst[31]}}, inst[31:20]};
          b.op_pc = 1'b1;
        end
        OPC_JAL: begin
          b.rd    = inst[11:7];
          b.imm   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
          b.op_pc = 1'b1;
        end
        OPC_LUI: begin
          b.rd  = inst[11:7];
          b.imm = {inst[31:12], 12'b0};
        end
        OPC_AUIPC: begin
          b.rd     = inst[11:7];
          b.imm    = {inst[31:12], 12'b0};
          b.op_pc  = 1'b1;
          b.op_imm = 1'b1;
        end
        OPC_FENCE, OPC_SYSTEM: begin
          b.rd  = inst[11:7];
          b.rs1 = inst[19:15];
          b.f3  = inst[14:12];
        end
        default: ;
      endcase
    end
    return b;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] en;
  bundle_t           bnd_q [STAGES];
  bundle_t           dec_bnd;
  bundle_t           out_bnd;

  assign dec_bnd = decode(iInst, iCurPc);

  // A stage may load when it or any stage after it has a bubble, or the consumer takes the head.
  always_comb begin
    logic chain;
    chain = iReady;
    en    = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      chain = chain | ~vld_q[s];
      en[s] = chain;
    end
  end

  assign oReady = en[0] & ~iFlush;

  always_comb begin
    vld_d = vld_q;
    if (iFlush) begin
      vld_d = '0;
    end else begin
      if (en[0]) vld_d[0] = iValid;
      for (int s = 1; s < STAGES; s++) begin
        if (en[s]) vld_d[s] = vld_q[s-1];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  // Payload registers carry no reset; outputs are masked by the head valid instead.
  always_ff @(posedge iClk) begin
    if (en[0]) bnd_q[0] <= dec_bnd;
    for (int s = 1; s < STAGES; s++) begin
      if (en[s]) bnd_q[s] <= bnd_q[s-1];
    end
  end

  assign oValid = vld_q[STAGES-1];

  always_comb begin
    out_bnd       = '0;
    out_bnd.arith = ARITH_NOP;
    if (oValid) out_bnd = bnd_q[STAGES-1];
  end

  assign oOpcode  = out_bnd.opcode;
  assign oRdAddr  = out_bnd.rd;
  assign oRs1Addr = out_bnd.rs1;
  assign oRs2Addr = out_bnd.rs2;
  assign oFunct3  = out_bnd.f3;
  assign oFunct7  = out_bnd.f7;
  assign oImm     = out_bnd.imm;
  assign oCurPc   = out_bnd.pc;
  assign oLoad    = out_bnd.load;
  assign oStore   = out_bnd.store;
  assign oOpRs1   = out_bnd.op_rs1;
  assign oOpRs2   = out_bnd.op_rs2;
  assign oOpImm   = out_bnd.op_imm;
  assign oOpPc    = out_bnd.op_pc;
  assign oArith   = out_bnd.arith;
  assign oIllegal = out_bnd.illegal;

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Scoreboard bench for inst_decode_pipe: hand-decoded instruction table, streaming, stall, flush, reset.
module tb_inst_decode_pipe;

  localparam int STAGES = 2;

  logic        iClk = 1'b0;
  logic        iRstN, iValid, iReady, iFlush;
  logic [31:0] iInst, iCurPc;
  logic        oReady, oValid;
  logic [6:0]  oOpcode, oFunct7;
  logic [4:0]  oRdAddr, oRs1Addr, oRs2Addr;
  logic [2:0]  oFunct3;
  logic [31:0] oImm, oCurPc;
  logic        oLoad, oStore, oOpRs1, oOpRs2, oOpImm, oOpPc, oIllegal;
  logic [3:0]  oArith;

  inst_decode_pipe #(.XLEN(32), .STAGES(STAGES), .CHECK_ILLEGAL(1)) dut (
    .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .oReady(oReady), .iInst(iInst),
    .iCurPc(iCurPc), .iFlush(iFlush), .oValid(oValid), .iReady(iReady),
    .oOpcode(oOpcode), .oRdAddr(oRdAddr), .oRs1Addr(oRs1Addr), .oRs2Addr(oRs2Addr),
    .oFunct3(oFunct3), .oFunct7(oFunct7), .oImm(oImm), .oCurPc(oCurPc),
    .oLoad(oLoad), .oStore(oStore), .oOpRs1(oOpRs1), .oOpRs2(oOpRs2),
    .oOpImm(oOpImm), .oOpPc(oOpPc), .oArith(oArith), .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  // fl = {load, store, op_rs1, op_rs2, op_imm, op_pc}
  typedef struct packed {
    logic [31:0] inst;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [3:0]  ar;
    logic [5:0]  fl;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  exp_t         tbl [16];
  exp_t         sb [$];
  exp_t         cur;
  int           n_vec = 0, n_err = 0, n_out = 0, cyc = 0;
  logic [127:0] snap, snap_now;
  bit           hold_v = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int i, input logic [31:0] inst, input logic [6:0] op,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                     input logic [3:0] ar, input logic [5:0] fl, input logic ill);
    tbl[i] = '{inst: inst, op: op, rd: rd, rs1: rs1, rs2: rs2, f3: f3, f7: f7,
               imm: imm, ar: ar, fl: fl, ill: ill, pc: 32'h0};
  endtask

  task automatic send(input int idx, input logic [31:0] pc);
    bit acc;
    int g;
    cur    = tbl[idx];
    cur.pc = pc;
    iInst  = tbl[idx].inst;
    iCurPc = pc;
    iValid = 1'b1;
    acc    = 1'b0;
    g      = 0;
    while (!acc && g < 50) begin
      @(negedge iClk);
      acc = oReady;
      @(posedge iClk);
      #1;
      g++;
    end
    if (!acc) check_eq("accept_timeout", oReady, 1);
  endtask

  initial forever begin
    @(posedge iClk);
    cyc++;
  end

  // Outputs are sampled on the falling edge; a transfer seen here completes on the next rising edge.
  initial forever begin
    exp_t e;
    @(negedge iClk);
    if (!iRstN || iFlush) begin
      sb.delete();
      hold_v = 1'b0;
    end else begin
      snap_now = {oValid, oOpcode, oRdAddr, oRs1Addr, oRs2Addr, oFunct3, oFunct7, oImm, oCurPc,
                  oLoad, oStore, oOpRs1, oOpRs2, oOpImm, oOpPc, oArith, oIllegal};
      if (hold_v) check_eq("stall_hold", snap_now, snap);
      hold_v = oValid && !iReady;
      snap   = snap_now;
      if (oValid && iReady) begin
        n_out++;
        if (sb.size() == 0) begin
          check_eq("unexpected_out", oValid, 0);
        end else begin
          e = sb.pop_front();
          check_eq($sformatf("%h.opcode", e.inst), oOpcode, e.op);
          check_eq($sformatf("%h.rd", e.inst), oRdAddr, e.rd);
          check_eq($sformatf("%h.rs1", e.inst), oRs1Addr, e.rs1);
          check_eq($sformatf("%h.rs2", e.inst), oRs2Addr, e.rs2);
          check_eq($sformatf("%h.funct3", e.inst), oFunct3, e.f3);
          check_eq($sformatf("%h.funct7", e.inst), oFunct7, e.f7);
          check_eq($sformatf("%h.imm", e.inst), oImm, e.imm);
          check_eq($sformatf("%h.pc", e.inst), oCurPc, e.pc);
          check_eq($sformatf("%h.arith", e.inst), oArith, e.ar);
          check_eq($sformatf("%h.flags", e.inst),
                   {oLoad, oStore, oOpRs1, oOpRs2, oOpImm, oOpPc}, e.fl);
          check_eq($sformatf("%h.illegal", e.inst), oIllegal, e.ill);
        end
      end
      if (iValid && oReady) sb.push_back(cur);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat, t0, n0, nf;
    //    idx inst          op     rd  rs1 rs2 f3 f7     imm            ar       fl         ill
    put(0,  32'hFFF10093, 7'h13, 1,  2,  0,  0, 7'h00, 32'hFFFFFFFF, 4'b0000, 6'b001010, 0);
    put(1,  32'h00532423, 7'h23, 0,  6,  5,  2, 7'h00, 32'h00000008, 4'b0000, 6'b011010, 0);
    put(2,  32'hFE000EE3, 7'h63, 0,  0,  0,  0, 7'h00, 32'hFFFFFFFC, 4'b1111, 6'b000000, 0);
    put(3,  32'h4030D093, 7'h13, 1,  1,  0,  5, 7'h00, 32'h00000403, 4'b1101, 6'b001010, 0);
    put(4,  32'h0030D093, 7'h13, 1,  1,  0,  5, 7'h00, 32'h00000003, 4'b0101, 6'b001010, 0);
    put(5,  32'h00000000, 7'h00, 0,  0,  0,  0, 7'h00, 32'h00000000, 4'b1111, 6'b000000, 1);
    put(6,  32'h0000707F, 7'h7F, 0,  0,  0,  0, 7'h00, 32'h00000000, 4'b1111, 6'b000000, 1);
    put(7,  32'h002081B3, 7'h33, 3,  1,  2,  0, 7'h00, 32'h00000000, 4'b0000, 6'b001100, 0);
    put(8,  32'h402081B3, 7'h33, 3,  1,  2,  0, 7'h20, 32'h00000000, 4'b1000, 6'b001100, 0);
    put(9,  32'h123452B7, 7'h37, 5,  0,  0,  0, 7'h00, 32'h12345000, 4'b1111, 6'b000000, 0);
    put(10, 32'h008000EF, 7'h6F, 1,  0,  0,  0, 7'h00, 32'h00000008, 4'b1111, 6'b000001, 0);
    put(11, 32'h00009067, 7'h67, 0,  0,  0,  0, 7'h00, 32'h00000000, 4'b1111, 6'b000000, 1);
    put(12, 32'h402091B3, 7'h33, 0,  0,  0,  0, 7'h00, 32'h00000000, 4'b1111, 6'b000000, 1);
    put(13, 32'h00001117, 7'h17, 2,  0,  0,  0, 7'h00, 32'h00001000, 4'b1111, 6'b000011, 0);
    put(14, 32'hFFC12203, 7'h03, 4,  2,  0,  2, 7'h00, 32'hFFFFFFFC, 4'b0000, 6'b101010, 0);
    put(15, 32'hFFC13203, 7'h03, 0,  0,  0,  0, 7'h00, 32'h00000000, 4'b1111, 6'b000000, 1);

    iRstN = 1'b0; iValid = 1'b0; iReady = 1'b0; iFlush = 1'b0;
    iInst = '0; iCurPc = '0;
    #12;
    check_eq("rst_valid", oValid, 0);
    check_eq("rst_arith", oArith, 4'b1111);
    check_eq("rst_imm", oImm, 0);
    check_eq("rst_opcode", oOpcode, 0);
    check_eq("rst_illegal", oIllegal, 0);
    @(negedge iClk);
    #2 iRstN = 1'b1;
    @(posedge iClk);
    #1;
    check_eq("rst_ready", oReady, 1);
    iReady = 1'b1;

    // single instruction latency
    send(0, 32'h00001000);
    iValid = 1'b0;
    lat = 1;
    while (!oValid && lat < 20) begin
      @(posedge iClk);
      #1;
      lat++;
    end
    check_eq("latency", lat, STAGES);
    repeat (STAGES + 2) @(posedge iClk);
    #1;

    // full table back to back
    t0 = cyc;
    for (int i = 0; i < 16; i++) send(i, 32'h00002000 + 32'(4 * i));
    iValid = 1'b0;
    check_eq("throughput", cyc - t0, 16);
    repeat (STAGES + 3) @(posedge iClk);
    #1;

    // five-instruction stream with a four-cycle downstream stall
    fork
      begin
        send(7, 32'h00003000);
        send(8, 32'h00003004);
        send(9, 32'h00003008);
        send(10, 32'h0000300C);
        send(13, 32'h00003010);
        iValid = 1'b0;
      end
      begin
        repeat (2) @(posedge iClk);
        #1 iReady = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check_eq("full_ready", oReady, 0);
        @(posedge iClk);
        #1 iReady = 1'b1;
      end
    join
    repeat (STAGES + 4) @(posedge iClk);
    #1;

    // flush with instructions in flight
    iReady = 1'b0;
    nf = (STAGES < 2) ? STAGES : 2;
    for (int k = 0; k < nf; k++) send(1 + k, 32'h00004000 + 32'(4 * k));
    cur    = tbl[3];
    iInst  = tbl[3].inst;
    iValid = 1'b1;
    iFlush = 1'b1;
    @(negedge iClk);
    check_eq("flush_ready", oReady, 0);
    @(posedge iClk);
    #1;
    check_eq("flush_valid", oValid, 0);
    iFlush = 1'b0;
    iValid = 1'b0;
    iReady = 1'b1;
    n0 = n_out;
    repeat (STAGES + 4) @(posedge iClk);
    #1;
    check_eq("flush_dropped", n_out, n0);

    // asynchronous reset with the pipe full
    iReady = 1'b0;
    for (int k = 0; k < STAGES; k++) send(14 + (k % 2), 32'h00005000 + 32'(4 * k));
    iValid = 1'b0;
    @(negedge iClk);
    #2 iRstN = 1'b0;
    #1;
    check_eq("arst_valid", oValid, 0);
    check_eq("arst_arith", oArith, 4'b1111);
    check_eq("arst_imm", oImm, 0);
    check_eq("arst_pc", oCurPc, 0);
    @(posedge iClk);
    @(negedge iClk);
    #2 iRstN = 1'b1;
    iReady = 1'b1;
    n0 = n_out;
    repeat (STAGES + 4) @(posedge iClk);
    #1;
    check_eq("arst_dropped", n_out, n0);
    check_eq("arst_ready", oReady, 1);
    check_eq("sb_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_decode_pipe.md
INST_DECODE_PIPE -- requirements
Module: inst_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, data/PC width; only 32 (RV32I) is supported.
REQ-002 Parameter STAGES, default 2, register stages from input accept to output (legal 1..3).
REQ-003 Parameter CHECK_ILLEGAL, default 1; 1 = illegal-instruction detection on, 0 = oIllegal tied 0.
REQ-004 iClk  in  1  single clock; all state on rising edge.
REQ-005 iRstN  in  1  asynchronous, active-low reset.
REQ-006 iValid  in  1  iInst/iCurPc valid.
REQ-007 oReady  out  1  block accepts input this cycle.
REQ-008 iInst  in  XLEN  instruction word.
REQ-009 iCurPc  in  XLEN  PC of iInst.
REQ-010 iFlush  in  1  discard all in-flight instructions.
REQ-011 oValid  out  1  decoded bundle valid.
REQ-012 iReady  in  1  downstream accepts bundle.
REQ-013 oOpcode 7, oRdAddr 5, oRs1Addr 5, oRs2Addr 5, oFunct3 3, oFunct7 7, oImm XLEN, oCurPc XLEN  out  decoded fields.
REQ-014 oLoad, oStore, oOpRs1, oOpRs2, oOpImm, oOpPc  out  1 each  operation/operand-select flags.
REQ-015 oArith  out  4  ALU op: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 1111 no-op.
REQ-016 oIllegal  out  1  bundle is an illegal instruction.

Function
REQ-017 Input transfer SHALL occur when iValid && oReady; output transfer when oValid && iReady.
REQ-018 Pipeline SHALL be elastic: a stage advances when the next stage is empty or advancing; oReady = first stage empty or advancing, and oReady SHALL be 0 while iFlush=1.
REQ-019 With iReady=1 continuously, latency SHALL be exactly STAGES cycles and throughput 1 instruction/cycle.
REQ-020 While oValid=1 and iReady=0, all outputs SHALL hold stable; no instruction lost, duplicated or reordered.
REQ-021 Immediates SHALL be sign-extended to XLEN: I (load, OP-IMM, JALR), S, B (bit0=0), J (bit0=0); U (LUI, AUIPC) = {inst[31:12],12'b0}; all other opcodes imm=0.
REQ-022 Unused address/funct fields per format (e.g. rd for store/branch, rs1/rs2 for LUI/JAL) SHALL be output as 0.
REQ-023 R-type: oArith={inst[30],funct3}, oOpRs1=oOpRs2=1; OP-IMM: oArith={funct3==101 ? inst[30] : 0, funct3}, oOpRs1=oOpImm=1; load/store: oLoad/oStore=1, oArith=0000, oOpRs1=oOpImm=1; AUIPC/JAL/JALR: oOpPc=1 (AUIPC also oOpImm); all others oArith=1111.
REQ-024 Illegal (CHECK_ILLEGAL=1): inst[1:0]!=11, opcode outside RV32I set, R-type funct7 not 0000000/0100000 or 0100000 with funct3 not 000/101, OP-IMM shift with funct7 not 0000000 (sll/srl) or 0100000 (srl/sra), load funct3 in {011,110,111}, store funct3>010, branch funct3 in {010,011}, JALR funct3!=000.
REQ-025 Illegal bundle SHALL still be delivered with oValid=1, oIllegal=1, all flags 0, oArith=1111, oOpcode/oCurPc passed through.
REQ-026 iFlush=1 at an edge SHALL clear every stage valid; oValid=0 next cycle; input on that cycle not accepted; flush dominates simultaneous advance.
REQ-027 Decode SHALL be pure function of the captured instruction; no state besides stage registers and valids.

Reset
REQ-028 iRstN=0 SHALL immediately clear all stage valids: oValid=0, all data outputs 0, oArith=1111, oIllegal=0.
REQ-029 oReady SHALL be 1 (iFlush=0) from the first cycle after reset release; reset mid-stream drops all in-flight instructions.

Verification
REQ-030 iInst=0xFFF10093 (addi x1,x2,-1), iReady=1 -> after STAGES cycles oOpcode=0x13, oRdAddr=1, oRs1Addr=2, oImm=0xFFFFFFFF, oArith=0000, oOpImm=1.
REQ-031 0x00532423 (sw x5,8(x6)) -> oStore=1, oRs1Addr=6, oRs2Addr=5, oRdAddr=0, oImm=0x00000008; 0xFE000EE3 (beq x0,x0,-4) -> oImm=0xFFFFFFFC.
REQ-032 0x4030D093 (srai x1,x1,3) -> oArith=1101, oImm=0x00000403; 0x0030D093 (srli) -> oArith=0101.
REQ-033 Stream 5 instructions, iReady=0 for 4 cycles mid-stream -> oReady falls when all STAGES full, outputs stable, all 5 received in order exactly once.
REQ-034 iInst=0x00000000 and 0x0000707F -> oIllegal=1, oValid=1, flags 0, oArith=1111; iFlush with 2 in flight -> oValid=0 next cycle, neither delivered.
REQ-035 iRstN asserted with STAGES instructions in flight -> outputs to reset values asynchronously, none delivered after release.
